// File: rtl/audio_sample_fifo.sv
`default_nettype none
// audio_sample_fifo: byte-write / frame-read PCM buffer assembling 8/16-bit mono/stereo frames.
// Build option AUDIO_SAMPLE_FIFO_HOLD_EN: an underrun frame repeats the previous samples instead of silence.
module audio_sample_fifo #(
    parameter int DEPTH_LOG2          = 12,
    parameter int ALMOST_EMPTY_THRESH = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [7:0]            wrdata,
    input  logic                  wr_en,
    input  logic                  mode_16bit,
    input  logic                  mode_stereo,
    input  logic                  rd_en,
    output logic                  busy,
    output logic                  sample_valid,
    output logic [15:0]           left,
    output logic [15:0]           right,
    output logic                  underrun,
    output logic                  overflow,
    output logic [DEPTH_LOG2-1:0] level,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  full
);
    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] AE_THRESH = ALMOST_EMPTY_THRESH[DEPTH_LOG2-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2,
        S_UNDER = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             mem_q [DEPTH];
    logic [7:0]             rdata_q;
    logic [DEPTH_LOG2-1:0]  wridx_q, rdidx_q;
    logic [1:0]             cnt_q;
    logic                   m16_q, st_q;
    logic                   pend_q;
    logic [1:0]             pend_slot_q;
    logic [3:0][7:0]        bytes_q;
    logic [15:0]            left_q, right_q;
    logic                   valid_q, under_q, ovf_q;

    logic [2:0]             need_w;
    logic                   enough_w, last_w, wr_ok_w;
    logic [3:0][7:0]        asm_bytes_w;
    logic [15:0]            asm_left_w, asm_right_w;

    assign level        = wridx_q - rdidx_q;
    assign empty        = (level == '0);
    assign full         = ((wridx_q + IDX_ONE) == rdidx_q);
    assign almost_empty = (level < AE_THRESH);
    assign busy         = (state_q == S_FETCH) || (state_q == S_DONE);
    assign sample_valid = valid_q;
    assign underrun     = under_q;
    assign overflow     = ovf_q;
    assign left         = left_q;
    assign right        = right_q;

    assign wr_ok_w  = wr_en && !full && !flush;
    assign need_w   = (mode_16bit && mode_stereo) ? 3'd4 :
                      (mode_16bit || mode_stereo) ? 3'd2 : 3'd1;
    assign enough_w = (32'(level) >= 32'(need_w));
    // Index of the final byte of the latched frame: k-1 for k = 1, 2, 4.
    assign last_w   = (cnt_q == {m16_q & st_q, m16_q | st_q});

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rd_en) state_d = enough_w ? S_FETCH : S_UNDER;
            S_FETCH: if (last_w) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_UNDER: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // The last fetched byte is still in the RAM output register during DONE.
    always_comb begin
        asm_bytes_w = bytes_q;
        if (pend_q) asm_bytes_w[pend_slot_q] = rdata_q;
        if (m16_q) begin
            asm_left_w  = {asm_bytes_w[1], asm_bytes_w[0]};
            asm_right_w = st_q ? {asm_bytes_w[3], asm_bytes_w[2]} : asm_left_w;
        end else begin
            asm_left_w  = {asm_bytes_w[0], 8'h00};
            asm_right_w = st_q ? {asm_bytes_w[1], 8'h00} : asm_left_w;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_w) mem_q[wridx_q] <= wrdata;
        rdata_q <= mem_q[rdidx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wridx_q     <= '0;
            rdidx_q     <= '0;
            cnt_q       <= 2'd0;
            m16_q       <= 1'b0;
            st_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_slot_q <= 2'd0;
            bytes_q     <= '0;
            left_q      <= 16'h0000;
            right_q     <= 16'h0000;
            valid_q     <= 1'b0;
            under_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            under_q <= 1'b0;
            if (flush) begin
                wridx_q <= '0;
                rdidx_q <= '0;
                cnt_q   <= 2'd0;
                pend_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (wr_en) begin
                    if (!full) wridx_q <= wridx_q + IDX_ONE;
                    else       ovf_q   <= 1'b1;
                end
                pend_q      <= (state_q == S_FETCH);
                pend_slot_q <= cnt_q;
                if (pend_q) bytes_q[pend_slot_q] <= rdata_q;
                case (state_q)
                    S_IDLE: begin
                        if (rd_en) begin
                            m16_q <= mode_16bit;
                            st_q  <= mode_stereo;
                            cnt_q <= 2'd0;
                        end
                    end
                    S_FETCH: begin
                        rdidx_q <= rdidx_q + IDX_ONE;
                        cnt_q   <= cnt_q + 2'd1;
                    end
                    S_DONE: begin
                        left_q  <= asm_left_w;
                        right_q <= asm_right_w;
                        valid_q <= 1'b1;
                    end
                    S_UNDER: begin
                        valid_q <= 1'b1;
                        under_q <= 1'b1;
`ifdef AUDIO_SAMPLE_FIFO_HOLD_EN
                        left_q  <= left_q;
                        right_q <= right_q;
`else
                        left_q  <= 16'h0000;
                        right_q <= 16'h0000;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_audio_sample_fifo.sv
`default_nettype none
// Bench for audio_sample_fifo: directed scenarios plus randomized traffic, checked by a frame scoreboard.
module tb_audio_sample_fifo;
    localparam int DL2 = 4;
    localparam int CAP = (1 << DL2) - 1;
    localparam int AE  = 4;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic mode_16bit = 1'b0, mode_stereo = 1'b0;
    logic [7:0] wrdata = 8'h00;
    logic busy, sample_valid, underrun, overflow, empty, almost_empty, full;
    logic [15:0] left, right;
    logic [DL2-1:0] level;

    audio_sample_fifo #(.DEPTH_LOG2(DL2), .ALMOST_EMPTY_THRESH(AE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wrdata(wrdata), .wr_en(wr_en),
        .mode_16bit(mode_16bit), .mode_stereo(mode_stereo), .rd_en(rd_en),
        .busy(busy), .sample_valid(sample_valid), .left(left), .right(right),
        .underrun(underrun), .overflow(overflow), .level(level), .empty(empty),
        .almost_empty(almost_empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ur;
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    int          n_cmp = 0, n_err = 0;
    frame_t      sb[$];
    logic [7:0]  mq[$];
    logic [15:0] prev_l = 16'h0, prev_r = 16'h0;
    logic        m_ovf = 1'b0;
    int          idle_wait = 0;
    int          n_written = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a byte queue; a request consumes a whole frame the moment it is accepted.
    task automatic model_edge(input bit wr, input logic [7:0] d, input bit rd, input bit m16, input bit st);
        int k, per, lv, rv;
        frame_t f;
        logic [7:0] b[4];
        if (rd && idle_wait == 0) begin
            per = m16 ? 2 : 1;
            k   = per * (st ? 2 : 1);
            if (mq.size() >= k) begin
                for (int i = 0; i < 4; i++) b[i] = (i < k) ? mq.pop_front() : 8'h00;
                lv = m16 ? (int'(b[0]) + 256 * int'(b[1])) : 256 * int'(b[0]);
                rv = st ? (m16 ? (int'(b[2]) + 256 * int'(b[3])) : 256 * int'(b[1])) : lv;
                f.ur = 1'b0; f.l = 16'(lv); f.r = 16'(rv);
                idle_wait = k + 1;
            end else begin
                f.ur = 1'b1;
`ifdef AUDIO_SAMPLE_FIFO_HOLD_EN
                f.l = prev_l; f.r = prev_r;
`else
                f.l = 16'h0; f.r = 16'h0;
`endif
                idle_wait = 1;
            end
            sb.push_back(f);
        end else if (idle_wait > 0) begin
            idle_wait--;
        end
        if (wr) begin
            if (mq.size() < CAP) begin mq.push_back(d); n_written++; end
            else m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit m16, input bit st);
        wr_en = wr; wrdata = d; rd_en = rd; mode_16bit = m16; mode_stereo = st;
        @(posedge clk);
        model_edge(wr, d, rd, m16, st);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        mq.delete(); sb.delete(); idle_wait = 0; m_ovf = 1'b0;
        #1;
        flush = 1'b0;
    endtask

    task automatic status(input string name);
        chk({name, "_level"}, 64'(level), 64'(mq.size()));
        chk({name, "_empty"}, 64'(empty), 64'(mq.size() == 0));
        chk({name, "_aempty"}, 64'(almost_empty), 64'(mq.size() < AE));
        chk({name, "_full"}, 64'(full), 64'(mq.size() == CAP));
        chk({name, "_ovf"}, 64'(overflow), 64'(m_ovf));
    endtask

    // Issue one request and measure cycles until sample_valid; mode pins wander afterwards.
    task automatic req_latency(input bit m16, input bit st, input int exp_lat, input bit exp_busy, input string name);
        int lat;
        drive(1'b0, 8'h00, 1'b1, m16, st);
        chk({name, "_busy"}, 64'(busy), 64'(exp_busy));
        for (lat = 1; lat <= 10; lat++) begin
            drive(1'b0, 8'h00, 1'b0, ~m16, ~st);
            if (sample_valid) break;
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        frame_t e;
        if (rst_n && sample_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_valid: got sample_valid=1 left=0x%0h expected no frame", left);
            end else begin
                e = sb.pop_front();
                chk("frame{ur,l,r}", 64'({underrun, left, right}), 64'(e));
                prev_l = e.l; prev_r = e.r;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        status("reset");
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(sample_valid), 64'd0);
        chk("reset_lr", 64'({left, right}), 64'd0);

        wr(8'h11); wr(8'h22); wr(8'h33);
        status("w3");
        wr(8'h44);
        status("w4");

        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        mq.delete(); sb.delete(); idle_wait = 0; m_ovf = 1'b0; prev_l = 16'h0; prev_r = 16'h0;
        status("async_rst");
        @(negedge clk); #2 rst_n = 1'b1;

        wr(8'h34); wr(8'h12); wr(8'hCD); wr(8'hAB);
        req_latency(1'b1, 1'b1, 5, 1'b1, "s16");
        status("s16");

        wr(8'h80);
        req_latency(1'b0, 1'b0, 2, 1'b1, "m8");
        status("m8");

        wr(8'h5A);
        req_latency(1'b1, 1'b0, 1, 1'b0, "under");
        status("under");

        do_flush();
        for (int i = 0; i < CAP; i++) wr(8'(i + 1));
        status("fill15");
        wr(8'hEE);
        status("fill16");
        do_flush();
        status("flush");

        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        idle(2);
        do_flush();
        idle(8);
        chk("abort_lr", 64'({left, right}), 64'({prev_l, prev_r}));
        status("abort");

        n_written = 0;
        for (int c = 0; c < 500; c++) begin
            drive(1'($urandom_range(0, 1)) && (mq.size() < CAP - 4), 8'($urandom),
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(10);
        chk("rand_bytes_streamed", 64'(n_written > 40), 64'd1);
        status("rand_end");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
